icache_dm: RTL



---
 rtl/icache_dm_pkg.sv | 34 +++
 rtl/icache_dm_if.sv | 31 +++
 rtl/icache_dm_array.sv | 45 ++++
 rtl/icache_dm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Contents:
//   S_OFFSET       byte-offset bits within a 32-byte line (fixed)
//   LINE_W         cache line width in bits
//   icache_state_t fill FSM states
//   addr_tag/addr_index/addr_word  address-split helpers
package icache_types;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned LINE_W   = 256;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILLED
  } icache_state_t;

  // Tag field, right-justified; caller truncates to its tag width.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned s_index);
    return addr >> (S_OFFSET + s_index);
  endfunction

  // Set index, right-justified; caller truncates to its index width.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned s_index);
    return (addr >> S_OFFSET) & ((32'd1 << s_index) - 32'd1);
  endfunction

  // 32-bit word within the line.
  function automatic logic [2:0] addr_word(input logic [31:0] addr);
    return 3'(addr >> 2);
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side bus bundle for icache_dm.
// Signals:
//   mem_read/mem_write/mem_address  fetch request from the pipeline
//   mem_rdata/mem_resp              fetched word and completion strobe
//   pmem_read/pmem_address          line-fill request to memory
//   pmem_rdata/pmem_resp            fill line data and one-cycle valid pulse
// Modports: slave = cache side, master = pipeline plus memory side.
interface icache_dm_if;
  import icache_types::*;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic              pmem_read;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_address
  );

  modport master (
    output mem_read, mem_write, mem_address, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_address
  );

endinterface

// File: rtl/icache_dm_array.sv
// Generic storage array: asynchronous read, synchronous write.
// Parameters: Width (entry bits), Depth (entries, power of two),
//             ClearOnReset (zero all entries while rst_n is low).
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   raddr/rdata combinational read port
//   we/waddr/wdata  synchronous write port (writes blocked during reset)
module icache_array #(
  parameter int unsigned Width        = 1,
  parameter int unsigned Depth        = 8,
  parameter bit          ClearOnReset = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata = mem_q[raddr];

  if (ClearOnReset) begin : g_clear
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= '0;
        end
      end else if (we) begin
        mem_q[waddr] <= wdata;
      end
    end
  end else begin : g_noclear
    // Contents are don't-care after reset; only suppress writes while in reset.
    always_ff @(posedge clk) begin
      if (we && rst_n) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only L1 instruction cache.
// Hits respond in the same cycle; a miss fetches one 256-bit line, spends one
// bubble cycle in FILLED, then re-looks-up and hits in IDLE.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         icache_dm_if.slave (fetch side mem_*, memory side pmem_*)
//   hit_count, miss_count  performance counters, present only when
//                          ICACHE_PERF_CNT_EN is defined
module icache_dm
  import icache_types::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_dm_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned S_TAG = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned Sets  = 1 << S_INDEX;

  icache_state_t state_q, state_d;
  logic [31:0]   fill_addr_q, fill_addr_d;

  logic [S_TAG-1:0]   req_tag, fill_tag, tag_rd;
  logic [S_INDEX-1:0] req_idx, fill_idx;
  logic [2:0]         req_word;
  logic               valid_rd;
  logic [LINE_W-1:0]  line_rd;
  logic               fill_we;
  logic               hit;
  logic               mem_resp;
  logic               pmem_read;
  logic [31:0]        pmem_address;

  assign req_tag  = S_TAG'(addr_tag(bus.mem_address, S_INDEX));
  assign req_idx  = S_INDEX'(addr_index(bus.mem_address, S_INDEX));
  assign req_word = addr_word(bus.mem_address);
  assign fill_tag = S_TAG'(addr_tag(fill_addr_q, S_INDEX));
  assign fill_idx = S_INDEX'(addr_index(fill_addr_q, S_INDEX));

  icache_array #(
    .Width        (1),
    .Depth        (Sets),
    .ClearOnReset (1'b1)
  ) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (req_idx),
    .rdata (valid_rd),
    .we    (fill_we),
    .waddr (fill_idx),
    .wdata (1'b1)
  );

  icache_array #(
    .Width        (S_TAG),
    .Depth        (Sets),
    .ClearOnReset (1'b0)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (req_idx),
    .rdata (tag_rd),
    .we    (fill_we),
    .waddr (fill_idx),
    .wdata (fill_tag)
  );

  icache_array #(
    .Width        (LINE_W),
    .Depth        (Sets),
    .ClearOnReset (1'b0)
  ) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (req_idx),
    .rdata (line_rd),
    .we    (fill_we),
    .waddr (fill_idx),
    .wdata (bus.pmem_rdata)
  );

  // Lookup is only meaningful in IDLE; FETCH/FILLED never respond.
  assign hit = (state_q == IDLE) && bus.mem_read && valid_rd && (tag_rd == req_tag);

  // Word mux is driven whenever the set is valid, independent of tag match.
  assign bus.mem_rdata = valid_rd ? line_rd[{req_word, 5'd0} +: 32] : 32'd0;

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_we      = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read) begin
          if (hit) begin
            mem_resp = 1'b1;
          end else begin
            fill_addr_d = {bus.mem_address[31:5], 5'd0};
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        // Fill always completes for the latched address, whatever mem_* does.
        pmem_read    = 1'b1;
        pmem_address = fill_addr_q;
        if (bus.pmem_resp) begin
          fill_we = 1'b1;
          state_d = FILLED;
        end
      end
      FILLED: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  assign bus.mem_resp     = mem_resp;
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_address = pmem_address;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (mem_resp) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == FETCH)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

`ifndef SYNTHESIS
  // The cache is read-only; a simultaneous write request indicates a pipeline bug.
  a_no_write_with_read: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.mem_write && bus.mem_read)
  );
`endif

endmodule
